// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA 640x480@60 timing defaults and RGB565 colour constants
//
// Used by vga_ctrl and the picture generators that feed it.
//   VGA_H_* / VGA_V_* : default segment widths of one line / one frame
//   RGB_*             : RGB565 colour constants
//   in_window()       : half-open range test [lo, hi) on 10-bit counter values

package vga_pkg;

    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 40;
    localparam int VGA_H_LEFT   = 8;
    localparam int VGA_H_VALID  = 640;
    localparam int VGA_H_RIGHT  = 8;
    localparam int VGA_H_FRONT  = 8;

    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 25;
    localparam int VGA_V_TOP    = 8;
    localparam int VGA_V_VALID  = 480;
    localparam int VGA_V_BOTTOM = 8;
    localparam int VGA_V_FRONT  = 2;

    localparam logic [15:0] RGB_BLACK   = 16'h0000;
    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;

    localparam logic [9:0]  PIX_NONE    = 10'h3FF;

    function automatic logic in_window(input logic [9:0] val,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_ctrl.sv
// rtl/vga_ctrl.sv - VGA timing generator with one-clock-ahead pixel request
//
// Ports:
//   vga_clk     : pixel clock, sole clock
//   sys_rst_n   : asynchronous active-low reset
//   pix_data    : RGB565 pixel from the picture stage, one clock after pix_x/pix_y
//   pix_x/pix_y : requested pixel column/row, 10'h3FF outside the request window
//   hsync/vsync : active-high sync pulses
//   rgb_valid   : active display region
//   rgb         : RGB565 to DAC, zero outside the active region
//   frame_start : high for the single cycle at counter position (0,0)

module vga_ctrl
    import vga_pkg::*;
#(
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BACK   = VGA_H_BACK,
    parameter int H_LEFT   = VGA_H_LEFT,
    parameter int H_VALID  = VGA_H_VALID,
    parameter int H_RIGHT  = VGA_H_RIGHT,
    parameter int H_FRONT  = VGA_H_FRONT,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BACK   = VGA_V_BACK,
    parameter int V_TOP    = VGA_V_TOP,
    parameter int V_VALID  = VGA_V_VALID,
    parameter int V_BOTTOM = VGA_V_BOTTOM,
    parameter int V_FRONT  = VGA_V_FRONT
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_valid,
    output logic [15:0] rgb,
    output logic        frame_start
);

    localparam logic [9:0] H_TOTAL     = 10'(H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT);
    localparam logic [9:0] V_TOTAL     = 10'(V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BACK + H_LEFT);
    localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BACK + H_LEFT + H_VALID);
    localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BACK + V_TOP);
    localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BACK + V_TOP + V_VALID);
    // The picture stage has one clock of latency, so requests lead display by one column.
    localparam logic [9:0] H_REQ_START = H_ACT_START - 10'd1;
    localparam logic [9:0] H_REQ_END   = H_ACT_END - 10'd1;

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       line_end;
    logic       v_act;
    logic       pix_data_req;

    assign line_end = (cnt_h == H_TOTAL - 10'd1);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h <= '0;
        end else if (line_end) begin
            cnt_h <= '0;
        end else begin
            cnt_h <= cnt_h + 10'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_v <= '0;
        end else if (line_end) begin
            if (cnt_v == V_TOTAL - 10'd1) begin
                cnt_v <= '0;
            end else begin
                cnt_v <= cnt_v + 10'd1;
            end
        end
    end

    assign v_act        = in_window(cnt_v, V_ACT_START, V_ACT_END);
    assign hsync        = (cnt_h < H_SYNC_END);
    assign vsync        = (cnt_v < V_SYNC_END);
    assign rgb_valid    = v_act && in_window(cnt_h, H_ACT_START, H_ACT_END);
    assign pix_data_req = v_act && in_window(cnt_h, H_REQ_START, H_REQ_END);
    assign pix_x        = pix_data_req ? (cnt_h - H_REQ_START) : PIX_NONE;
    assign pix_y        = pix_data_req ? (cnt_v - V_ACT_START) : PIX_NONE;
    assign rgb          = rgb_valid ? pix_data : RGB_BLACK;
    assign frame_start  = (cnt_h == 10'd0) && (cnt_v == 10'd0);

endmodule

// File: tb/tb_vga_ctrl.sv
// tb/tb_vga_ctrl.sv - self-checking bench for vga_ctrl

module tb_vga_ctrl;

    localparam int HT    = 800;
    localparam int VT    = 15;
    localparam int FRAME = HT * VT;
    localparam int VA0   = 7;
    localparam int VA1   = 11;

    logic        vga_clk;
    logic        sys_rst_n;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        hsync;
    logic        vsync;
    logic        rgb_valid;
    logic [15:0] rgb;
    logic        frame_start;

    int total;
    int bad;
    int pos;
    int hs_cnt, vs_cnt, fs_cnt;
    bit frame_full;

    vga_ctrl #(
        .V_BACK   (3),
        .V_TOP    (2),
        .V_VALID  (4),
        .V_BOTTOM (2)
    ) dut (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb_valid   (rgb_valid),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    // Picture stage: one-clock registered column index.
    always @(posedge vga_clk) pix_data <= {6'b0, pix_x};

    // Position in the frame, as a single cycle index since the last reset.
    always @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) pos <= 0;
        else            pos <= (pos + 1) % FRAME;
    end

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at pos=%0d actual=%h required=%h", nm, pos, act, exp);
        end
    endtask

    function automatic logic [39:0] expect_at(input int p);
        int h, v;
        logic e_hs, e_vs, e_val, e_fs, req;
        logic [9:0] e_px, e_py;
        logic [15:0] e_rgb;
        h     = p % HT;
        v     = p / HT;
        e_hs  = (h < 96);
        e_vs  = (v < 2);
        e_val = (h >= 144) && (h < 784) && (v >= VA0) && (v < VA1);
        req   = (h >= 143) && (h < 783) && (v >= VA0) && (v < VA1);
        e_px  = req ? 10'(h - 143) : 10'h3FF;
        e_py  = req ? 10'(v - VA0) : 10'h3FF;
        e_rgb = e_val ? 16'(h - 144) : 16'h0000;
        e_fs  = (p == 0);
        return {e_hs, e_vs, e_val, e_fs, e_px, e_py, e_rgb};
    endfunction

    always @(negedge vga_clk) begin
        chk("cycle", {hsync, vsync, rgb_valid, frame_start, pix_x, pix_y, rgb}, expect_at(pos));

        if (!sys_rst_n) begin
            frame_full = 1'b0;
            chk("rst_outs", {hsync, vsync, rgb_valid, frame_start, pix_x, pix_y, rgb},
                {1'b1, 1'b1, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 16'h0000});
        end else begin
            if (pos == 0) begin
                frame_full = 1'b1;
                hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
            end
            hs_cnt += (pos < HT && hsync) ? 1 : 0;
            vs_cnt += vsync ? 1 : 0;
            fs_cnt += frame_start ? 1 : 0;
            if (frame_full && pos == HT - 1) chk("hsync_line0", 40'(hs_cnt), 40'd96);
            if (frame_full && pos == FRAME - 1) begin
                chk("vsync_frame", 40'(vs_cnt), 40'd1600);
                chk("fs_frame", 40'(fs_cnt), 40'd1);
            end

            case (pos)
                0 * HT + 95:  chk("hs_95", 40'(hsync), 40'd1);
                0 * HT + 96:  chk("hs_96", 40'(hsync), 40'd0);
                1 * HT + 799: chk("vs_1_799", 40'(vsync), 40'd1);
                2 * HT + 0:   chk("vs_2_0", 40'(vsync), 40'd0);
                6 * HT + 400: chk("row6", 40'({rgb_valid, pix_y}), {29'd0, 1'b0, 10'h3FF});
                7 * HT + 142: chk("px_142", 40'(pix_x), 40'h3FF);
                7 * HT + 143: chk("req_143", 40'({rgb_valid, pix_x, pix_y}), 40'd0);
                7 * HT + 144: chk("disp_144", 40'({rgb_valid, rgb}), {23'd0, 1'b1, 16'd0});
                7 * HT + 782: chk("px_782", 40'(pix_x), 40'd639);
                7 * HT + 783: chk("disp_783", 40'({rgb_valid, pix_x, rgb}),
                                  {13'd0, 1'b1, 10'h3FF, 16'd639});
                7 * HT + 784: chk("val_784", 40'(rgb_valid), 40'd0);
                10 * HT + 400: chk("row10", 40'({pix_x, pix_y, rgb}), {4'd0, 10'd257, 10'd3, 16'd256});
                11 * HT + 400: chk("row11", 40'({rgb_valid, pix_y}), {29'd0, 1'b0, 10'h3FF});
                default: ;
            endcase
        end
    end

    initial begin
        total = 0;
        bad = 0;
        frame_full = 1'b0;
        hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        sys_rst_n = 1'b0;
        repeat (3) @(posedge vga_clk);
        #2 sys_rst_n = 1'b1;
        repeat (2 * FRAME) @(posedge vga_clk);
        // Now at (0,0); move to (400, 9) inside the active region and abort the frame.
        repeat (9 * HT + 400) @(posedge vga_clk);
        #2 sys_rst_n = 1'b0;
        repeat (3) @(posedge vga_clk);
        #2 sys_rst_n = 1'b1;
        repeat (FRAME + 10) @(posedge vga_clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_ctrl.md
VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 SHALL have parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-002 SHALL have parameter H_BACK, default 40, horizontal back porch.
REQ-003 SHALL have parameter H_LEFT, default 8, left border.
REQ-004 SHALL have parameter H_VALID, default 640, active pixels per line.
REQ-005 SHALL have parameter H_RIGHT, default 8, right border.
REQ-006 SHALL have parameter H_FRONT, default 8, horizontal front porch; H_TOTAL = sum of the six horizontal parameters = 800.
REQ-007 SHALL have parameters V_SYNC 2, V_BACK 25, V_TOP 8, V_VALID 480, V_BOTTOM 8, V_FRONT 2 (lines); V_TOTAL = 525.
REQ-008 SHALL have port vga_clk, input, 1, pixel clock (25 MHz); sole clock.
REQ-009 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port pix_data, input, 16, RGB565 pixel from the picture generator.
REQ-011 SHALL have port pix_x, output, 10, requested pixel column.
REQ-012 SHALL have port pix_y, output, 10, requested pixel row.
REQ-013 SHALL have port hsync, output, 1, horizontal sync, active high.
REQ-014 SHALL have port vsync, output, 1, vertical sync, active high.
REQ-015 SHALL have port rgb_valid, output, 1, active display region flag.
REQ-016 SHALL have port rgb, output, 16, RGB565 to DAC.
REQ-017 SHALL have port frame_start, output, 1, one-clock pulse at start of each frame.

Function
REQ-018 cnt_h SHALL count 0..H_TOTAL-1 every vga_clk, wrapping 799 -> 0.
REQ-019 cnt_v SHALL increment only on the cycle cnt_h == H_TOTAL-1, wrapping V_TOTAL-1 -> 0 when cnt_h also wraps.
REQ-020 hsync SHALL be 1 when cnt_h <= H_SYNC-1 (0..95), else 0.
REQ-021 vsync SHALL be 1 when cnt_v <= V_SYNC-1 (0..1), else 0.
REQ-022 rgb_valid SHALL be 1 when cnt_h in [H_SYNC+H_BACK+H_LEFT, that+H_VALID) = [144,784) and cnt_v in [V_SYNC+V_BACK+V_TOP, that+V_VALID) = [35,515).
REQ-023 Internal pix_data_req SHALL equal rgb_valid advanced by one clock: cnt_h in [143,783), same cnt_v window.
REQ-024 pix_x SHALL be cnt_h-143 and pix_y SHALL be cnt_v-35 while pix_data_req = 1; both SHALL be 10'h3FF otherwise.
REQ-025 Upstream picture stage SHALL deliver pix_data with exactly one clock latency from pix_x/pix_y; rgb SHALL be pix_data when rgb_valid = 1, else 16'h0000.
REQ-026 First pixel of each line SHALL be requested with pix_x = 0 at cnt_h = 143 and displayed at cnt_h = 144; last request pix_x = 639 at cnt_h = 782.
REQ-027 frame_start SHALL pulse 1 for exactly the single cycle cnt_h == 0 and cnt_v == 0.
REQ-028 hsync, vsync, rgb_valid, pix_x, pix_y, rgb SHALL be combinational decodes of the counters (plus pix_data); frame_start SHALL be combinational.
REQ-029 All width arithmetic SHALL be 10 bits unsigned; no counter value outside 0..799 / 0..524 SHALL be reachable.

Reset
REQ-030 On sys_rst_n = 0, cnt_h and cnt_v SHALL clear to 0 asynchronously.
REQ-031 During reset, outputs SHALL read hsync = 1, vsync = 1, rgb_valid = 0, rgb = 0, pix_x = pix_y = 10'h3FF, frame_start = 1 (counters at 0,0).
REQ-032 Reset asserted mid-frame SHALL abort the frame; after release counting SHALL restart at cnt_h = 0, cnt_v = 0 on the first rising edge.

Structure
REQ-033 Timing parameters' default values and the RGB565 colour constants SHALL live in a shared package vga_pkg reused by the picture generators.
REQ-034 No sub-module is required; horizontal and vertical counters SHALL be inline.

Verification
REQ-035 Release reset, run 800 clocks -> hsync high cycles 0..95, low 96..799; cnt_v advances to 1 at clock 800.
REQ-036 Run full frame (420000 clocks) -> vsync high for exactly 1600 clocks, frame_start pulses once per 420000 clocks.
REQ-037 Line cnt_v = 35: pix_x = 3FF at cnt_h 142, 0 at 143, 639 at 782, 3FF at 783; rgb_valid 1 on cnt_h 144..783.
REQ-038 Model picture stage returning pix_data = {6'b0, pix_x} registered -> rgb equals column index 0..639 across active line, 0 elsewhere.
REQ-039 cnt_v = 34 and cnt_v = 515 lines -> rgb_valid = 0, pix_y = 3FF throughout.
REQ-040 Assert sys_rst_n = 0 at cnt_h = 400, cnt_v = 200 for 3 clocks -> outputs per REQ-031 immediately; frame restarts at (0,0), frame_start pulses on release.
